fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, 4, prefetch queue entries and maximum outstanding requests; power of two, 2..16.
REQ-002 Parameter RESET_VEC, 32'h00000000, fetch address after reset.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port resetb  in  1  asynchronous, active-low reset.
REQ-005 Port im_req  out  1  instruction fetch request valid.
REQ-006 Port im_addr  out  32  fetch address; word aligned whenever im_req=1.
REQ-007 Port im_gnt  in  1  request accepted when im_req&im_gnt.
REQ-008 Port im_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
REQ-009 Port im_rdata  in  32  response instruction word.
REQ-010 Port redirect  in  1  flush and restart fetch at redirect_pc (branch, jump, exception vector, mret).
REQ-011 Port redirect_pc  in  32  new fetch target.
REQ-012 Port fd_valid  out  1  instruction available to decode.
REQ-013 Port fd_ready  in  1  decode consumes; transfer when fd_valid&fd_ready.
REQ-014 Port fd_inst  out  32  instruction word.
REQ-015 Port fd_pc  out  32  address of fd_inst.
REQ-016 Port fd_misaligned  out  1  redirect target not word aligned.
REQ-017 Port perf_fetched  out  32  count of decode transfers.
REQ-018 Port perf_starved  out  32  count of cycles with fd_ready=1 and fd_valid=0.

Function
REQ-019 fetch_pc register drives im_addr and increments by 4 on each grant; wraps modulo 2^32.
REQ-020 im_req=1 only when outstanding+queue_count < DEPTH, no redirect this cycle, no misaligned state; pops free credit from the next cycle.
REQ-021 Accepted responses (not dropped) are written into a DEPTH-entry circular queue; fd_valid derives from registered queue state only, with no combinational path from im_rvalid.
REQ-022 head_pc register drives fd_pc; it increments by 4 on each transfer.
REQ-023 On redirect: queue flushed, fetch_pc and head_pc <= redirect_pc, drop_cnt <= outstanding responses not yet returned, excluding any response in the same cycle.
REQ-024 A response in the redirect cycle is discarded; responses while drop_cnt>0 are discarded and decrement drop_cnt.
REQ-025 Redirect has priority over a simultaneous transfer; that transfer is not counted and head_pc takes redirect_pc.
REQ-026 A new request may issue while drop_cnt>0 if credit allows.
REQ-027 redirect_pc[1:0]!=0 enters misaligned state: no requests issued. fd_valid=1, fd_misaligned=1, fd_pc=redirect_pc, fd_inst=32'h00000013. The state persists across transfers and is left only by the next redirect.
REQ-028 Queue full: no request; in-flight responses always have a free entry (guaranteed by REQ-020).

Reset
REQ-029 resetb low asynchronously sets: fetch_pc=head_pc=RESET_VEC, queue empty, outstanding=0, drop_cnt=0, misaligned state clear, fd_valid=0, perf counters 0.
REQ-030 im_req=1 with im_addr=RESET_VEC in the first cycle after resetb deasserts.
REQ-031 Reset mid-operation abandons in-flight responses; the memory side is reset by the same resetb.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN defined: perf_fetched and perf_starved are saturating 32-bit counters per REQ-017/018.
REQ-033 Macro FETCH_PERF_CNT_EN undefined: counter logic is absent and both outputs are constant 0.

Verification
REQ-034 Reset release, im_gnt=1, 1-cycle latency, fd_ready=1 -> fd_pc sequence 0,4,8,...; fd_valid first high 2 cycles after first grant.
REQ-035 fd_ready=0, DEPTH=4, gnt=1 -> exactly 4 grants (addr 0..C); im_req then held 0 until a transfer occurs.
REQ-036 Redirect to 0x100 with 3 outstanding, responses at latency 3 -> 3 responses dropped; next fd_pc=0x100 with the word fetched from 0x100.
REQ-037 Redirect to 0x102 -> no further im_req; fd_valid=1, fd_misaligned=1, fd_pc=0x102, fd_inst=0x00000013 held; redirect to 0x4 resumes fetch.
REQ-038 Redirect and fd_ready with fd_valid=1 in the same cycle -> perf_fetched unchanged; next fd_pc=redirect_pc.
REQ-039 With FETCH_PERF_CNT_EN, fd_ready=1 and im_gnt=0 for 10 cycles after reset -> perf_starved=10 and perf_fetched=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: in-order prefetch queue with credit-limited requests, redirect flush and response dropping.
// Optional saturating performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetb,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fd_valid,
    input  logic        fd_ready,
    output logic [31:0] fd_inst,
    output logic [31:0] fd_pc,
    output logic        fd_misaligned,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_starved
);

    localparam int          PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;
    logic [31:0]   queue_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic          misaligned;

    logic [CW:0]   in_use;
    logic          has_credit;
    logic          grant;
    logic          accept;
    logic          transfer;
    logic          pop;

    // Every in-flight request owns a queue slot, so a returning response can never overflow.
    assign in_use     = {1'b0, outstanding} + {1'b0, count};
    assign has_credit = in_use < (CW + 1)'(DEPTH);

    assign im_req   = !misaligned && !redirect && has_credit;
    assign im_addr  = fetch_pc;
    assign grant    = im_req && im_gnt;
    assign accept   = im_rvalid && !redirect && (drop_cnt == '0);

    assign fd_valid      = misaligned || (count != '0);
    assign fd_misaligned = misaligned;
    assign fd_pc         = head_pc;
    assign fd_inst       = misaligned ? NOP : queue_mem[rd_ptr];
    assign transfer      = fd_valid && fd_ready && !redirect;
    assign pop           = transfer && !misaligned;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            fetch_pc    <= RESET_VEC;
            head_pc     <= RESET_VEC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            misaligned  <= 1'b0;
        end else if (redirect) begin
            // Responses still owed by memory after this cycle belong to the old path.
            fetch_pc    <= redirect_pc;
            head_pc     <= redirect_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(im_rvalid);
            drop_cnt    <= outstanding - CW'(im_rvalid);
            misaligned  <= (redirect_pc[1:0] != 2'b00);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                head_pc <= head_pc + 32'd4;
                rd_ptr  <= rd_ptr + PW'(1);
            end
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (im_rvalid && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            outstanding <= outstanding + CW'(grant) - CW'(im_rvalid);
            count       <= count + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            queue_mem[wr_ptr] <= im_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            perf_fetched <= '0;
            perf_starved <= '0;
        end else begin
            if (transfer && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (fd_ready && !fd_valid && (perf_starved != 32'hFFFF_FFFF)) begin
                perf_starved <= perf_starved + 32'd1;
            end
        end
    end
`else
    assign perf_fetched = 32'h0;
    assign perf_starved = 32'h0;
`endif

endmodule
